// File: rtl/byte_match_unit_if.sv
// Request/result bundle between the EX stage and the bit-serial byte matcher.
// The EX side drives the request fields; the matcher drives status and result.
interface byte_match_unit_if;
   logic        start;
   logic        cancel;
   logic [7:0]  pattern;
   logic [31:0] data;
   logic [31:0] result;
   logic        valid;
   logic        busy;
   logic        stallreq;

   modport master (
      output start, cancel, pattern, data,
      input  result, valid, busy, stallreq
   );

   modport slave (
      input  start, cancel, pattern, data,
      output result, valid, busy, stallreq
   );
endinterface

// File: rtl/byte_match_unit.sv
// Bit-serial byte matcher: scans a word one bit offset per cycle and reports the
// lowest offset where the pattern byte occurs, stalling EX while it works.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   ST_IDLE | waiting for start; operands not yet latched
//   ST_SCAN | testing offset pos against sh[7:0]; one offset per cycle
//   ST_DONE | result presented with valid for exactly one cycle
module byte_match_unit #(
   parameter int SCAN_LEN = 25
) (
   input  logic               clk,
   input  logic               resetn,
   byte_match_unit_if.slave   bus
);

   localparam int PW = (SCAN_LEN > 1) ? $clog2(SCAN_LEN) : 1;
   localparam logic [PW-1:0] POS_LAST = PW'(SCAN_LEN - 1);
   localparam logic [31:0]   NO_MATCH = 32'hFFFF_FFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [31:0]   sh;
   logic [7:0]    pat;
   logic [PW-1:0] pos;
   logic [31:0]   result;
   logic [31:0]   result_nx;
   logic          load;
   logic          shift;
   logic          accept;

   // A new request can only be taken when no scan is in flight; a flush wins.
   assign accept = (state != ST_SCAN) & ~bus.cancel;

   always_comb begin
      state_nx  = state;
      result_nx = result;
      load      = 1'b0;
      shift     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (bus.start & ~bus.cancel) begin
               state_nx = ST_SCAN;
               load     = 1'b1;
            end
         end
         ST_SCAN: begin
            if (bus.cancel) begin
               state_nx = ST_IDLE;
            end else if (sh[7:0] == pat) begin
               state_nx  = ST_DONE;
               result_nx = 32'(pos);
            end else if (pos == POS_LAST) begin
               state_nx  = ST_DONE;
               result_nx = NO_MATCH;
            end else begin
               shift = 1'b1;
            end
         end
         ST_DONE: begin
            if (bus.start & ~bus.cancel) begin
               state_nx = ST_SCAN;
               load     = 1'b1;
            end else begin
               state_nx = ST_IDLE;
            end
         end
         default: begin
            state_nx = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state  <= ST_IDLE;
         sh     <= '0;
         pat    <= '0;
         pos    <= '0;
         result <= '0;
      end else begin
         state  <= state_nx;
         result <= result_nx;
         if (load) begin
            sh  <= bus.data;
            pat <= bus.pattern;
            pos <= '0;
         end else if (shift) begin
            sh  <= sh >> 1;
            pos <= pos + 1'b1;
         end
      end
   end

   assign bus.result   = result;
   assign bus.valid    = (state == ST_DONE);
   assign bus.busy     = (state == ST_SCAN);
   assign bus.stallreq = (bus.start & accept) | (state == ST_SCAN);

endmodule

// File: tb/tb_byte_match_unit.sv
// Bench for byte_match_unit: directed and random requests compared against a
// plain search model of "lowest bit offset where the byte appears".
module tb_byte_match_unit;

   localparam int SCAN_LEN = 25;
   localparam logic [31:0] NO_MATCH = 32'hFFFF_FFFF;

   logic clk;
   logic resetn;
   int   checks;
   int   failures;

   byte_match_unit_if bus ();

   byte_match_unit #(.SCAN_LEN(SCAN_LEN)) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] ref_match(input logic [7:0] p, input logic [31:0] d);
      for (int k = 0; k < SCAN_LEN; k++) begin
         if (8'(d >> k) == p) return 32'(k);
      end
      return NO_MATCH;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One request from cycle 0; verifies latency, result and stall/busy window.
   task automatic do_req(input logic [7:0] p, input logic [31:0] d, input string tag);
      logic [31:0] er;
      logic [31:0] rv;
      int          lat;
      int          vcyc;
      bit          win_ok;
      er  = ref_match(p, d);
      lat = (er == NO_MATCH) ? SCAN_LEN + 1 : int'(er) + 2;
      @(negedge clk);
      bus.start   = 1'b1;
      bus.pattern = p;
      bus.data    = d;
      #1;
      chk({tag, "_stall_c0"}, 32'(bus.stallreq), 32'd1);
      vcyc   = -1;
      win_ok = 1'b1;
      rv     = 'x;
      for (int c = 1; c <= SCAN_LEN + 8 && vcyc < 0; c++) begin
         @(negedge clk);
         bus.start   = 1'b0;
         bus.pattern = 8'($urandom);
         bus.data    = $urandom;
         #1;
         if (bus.stallreq !== (c < lat) || bus.busy !== (c < lat)) win_ok = 1'b0;
         if (bus.valid === 1'b1) begin
            vcyc = c;
            rv   = bus.result;
         end
      end
      chk({tag, "_latency"}, 32'(vcyc), 32'(lat));
      chk({tag, "_result"}, rv, er);
      chk({tag, "_stall_window"}, 32'(win_ok), 32'd1);
   endtask

   initial begin
      int          vseen;
      int          vcyc;
      logic [31:0] rv;
      logic [7:0]  rp;
      logic [31:0] rd;
      int          k;

      checks      = 0;
      failures    = 0;
      resetn      = 1'b0;
      bus.start   = 1'b0;
      bus.cancel  = 1'b0;
      bus.pattern = '0;
      bus.data    = '0;
      #12;
      chk("rst_result", bus.result, 32'd0);
      chk("rst_valid", 32'(bus.valid), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_stall", 32'(bus.stallreq), 32'd0);
      bus.start = 1'b1;
      #1;
      chk("rst_stall_start", 32'(bus.stallreq), 32'd1);
      bus.start = 1'b0;
      @(negedge clk);
      resetn = 1'b1;

      do_req(8'hAB, 32'h0000_00AB, "off0");
      do_req(8'h5A, 32'h0000_0B40, "off5");
      do_req(8'hAB, 32'hAB00_0000, "off24");
      do_req(8'hFF, 32'h0000_0000, "nomatch");
      do_req(8'h00, 32'hFFFF_FF00, "zero_pat");

      for (int i = 0; i < 20; i++) begin
         rp = 8'($urandom);
         rd = $urandom;
         if ($urandom_range(0, 1) == 1) begin
            k  = $urandom_range(0, SCAN_LEN - 1);
            rd = (rd & ~(32'hFF << k)) | (32'(rp) << k);
         end
         do_req(rp, rd, "rand");
      end

      // Back-to-back: second start lands in the DONE cycle of the first.
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 8'hAB; bus.data = 32'h0000_00AB;
      @(negedge clk);
      bus.start = 1'b0; bus.pattern = 8'h00; bus.data = 32'h0;
      @(negedge clk);
      #1;
      chk("b2b_first_valid", 32'(bus.valid), 32'd1);
      chk("b2b_first_result", bus.result, 32'd0);
      bus.start = 1'b1; bus.pattern = 8'h01; bus.data = 32'h0000_0002;
      #1;
      chk("b2b_stall_in_done", 32'(bus.stallreq), 32'd1);
      vcyc = -1; rv = 'x;
      for (int c = 1; c <= 10 && vcyc < 0; c++) begin
         @(negedge clk);
         bus.start = 1'b0; bus.data = 32'h0;
         #1;
         if (bus.valid === 1'b1) begin vcyc = c; rv = bus.result; end
      end
      chk("b2b_second_latency", 32'(vcyc), 32'd3);
      chk("b2b_second_result", rv, 32'd1);

      // Start during SCAN with other operands is ignored.
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 8'h5A; bus.data = 32'h0000_0B40;
      vcyc = -1; rv = 'x; vseen = 0;
      for (int c = 1; c <= 15; c++) begin
         @(negedge clk);
         bus.start   = (c == 2);
         bus.pattern = 8'hAB;
         bus.data    = 32'h0000_00AB;
         #1;
         if (bus.valid === 1'b1) begin
            vseen++;
            if (vcyc < 0) begin vcyc = c; rv = bus.result; end
         end
      end
      chk("scan_start_latency", 32'(vcyc), 32'd7);
      chk("scan_start_result", rv, 32'd5);
      chk("scan_start_one_valid", 32'(vseen), 32'd1);

      // Cancel in cycle 3 of a full-length scan.
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 8'hFF; bus.data = 32'h0;
      @(negedge clk); bus.start = 1'b0;
      @(negedge clk);
      @(negedge clk); bus.cancel = 1'b1;
      @(negedge clk); bus.cancel = 1'b0;
      #1;
      chk("cancel_busy", 32'(bus.busy), 32'd0);
      chk("cancel_stall", 32'(bus.stallreq), 32'd0);
      vseen = 0;
      for (int c = 0; c < SCAN_LEN + 5; c++) begin
         @(negedge clk); #1;
         if (bus.valid === 1'b1) vseen++;
      end
      chk("cancel_no_valid", 32'(vseen), 32'd0);

      // Cancel together with start in IDLE.
      @(negedge clk);
      bus.start = 1'b1; bus.cancel = 1'b1; bus.pattern = 8'hAB; bus.data = 32'hAB;
      #1;
      chk("cancel_start_stall", 32'(bus.stallreq), 32'd0);
      @(negedge clk);
      bus.start = 1'b0; bus.cancel = 1'b0;
      vseen = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (bus.busy === 1'b1 || bus.valid === 1'b1) vseen++;
         @(negedge clk);
      end
      chk("cancel_start_idle", 32'(vseen), 32'd0);

      // Reset asserted in cycle 10 of a scan; result holds a nonzero value beforehand.
      @(negedge clk);
      bus.start = 1'b1; bus.pattern = 8'hFF; bus.data = 32'h0;
      @(negedge clk); bus.start = 1'b0;
      for (int c = 2; c <= 10; c++) @(negedge clk);
      #2;
      resetn = 1'b0;
      #1;
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_valid", 32'(bus.valid), 32'd0);
      chk("midrst_result", bus.result, 32'd0);
      @(negedge clk);
      resetn = 1'b1;
      do_req(8'h3C, 32'h0000_3C00, "post_rst");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
